// File: rtl/baud_tick_gen_if.sv
// Config and tick signals between the register block, baud_tick_gen and the UART Rx/Tx engines.
// The master drives the divisor/control inputs; the slave (the generator) drives the ticks.
interface baud_tick_gen_if #(
  parameter int unsigned DIV_INT_WIDTH  = 16,
  parameter int unsigned DIV_FRAC_WIDTH = 4,
  parameter int unsigned RX_OVERSAMPLE  = 16
) ();

  localparam int unsigned PhW = $clog2(RX_OVERSAMPLE);

  logic                      i_enable;
  logic                      i_sync_restart;
  logic                      i_cfg_load;
  logic [DIV_INT_WIDTH-1:0]  i_div_int;
  logic [DIV_FRAC_WIDTH-1:0] i_div_frac;
  logic                      o_cfg_pending;
  logic                      o_Rx_clkTick;
  logic                      o_Tx_clkTick;
  logic [PhW-1:0]            o_Rx_phase;

  modport master (
    output i_enable,
    output i_sync_restart,
    output i_cfg_load,
    output i_div_int,
    output i_div_frac,
    input  o_cfg_pending,
    input  o_Rx_clkTick,
    input  o_Tx_clkTick,
    input  o_Rx_phase
  );

  modport slave (
    input  i_enable,
    input  i_sync_restart,
    input  i_cfg_load,
    input  i_div_int,
    input  i_div_frac,
    output o_cfg_pending,
    output o_Rx_clkTick,
    output o_Tx_clkTick,
    output o_Rx_phase
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversampled Rx tick plus derived Tx tick, with a shadowed
// divisor that only takes effect on a tick boundary, a restart, or while disabled.
module baud_tick_gen #(
  parameter int unsigned DIV_INT_WIDTH    = 16,
  parameter int unsigned DIV_FRAC_WIDTH   = 4,
  parameter int unsigned RX_OVERSAMPLE    = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 13,
  parameter int unsigned DEFAULT_DIV_FRAC = 9
) (
  input  logic           clk,
  input  logic           reset,
  baud_tick_gen_if.slave bus
);

  localparam int unsigned CntW = DIV_INT_WIDTH + 1;
  localparam int unsigned PhW  = $clog2(RX_OVERSAMPLE);

  localparam logic [PhW-1:0]            PhLast  = PhW'(RX_OVERSAMPLE - 1);
  localparam logic [DIV_INT_WIDTH-1:0]  RstInt  = DIV_INT_WIDTH'(DEFAULT_DIV_INT);
  localparam logic [DIV_FRAC_WIDTH-1:0] RstFrac = DIV_FRAC_WIDTH'(DEFAULT_DIV_FRAC);

  // A zero integer divisor behaves as one, so the period never drops below a cycle.
  function automatic logic [CntW-1:0] eff_int(input logic [DIV_INT_WIDTH-1:0] v);
    return (v == '0) ? CntW'(1) : CntW'(v);
  endfunction

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [CntW-1:0]           per_q, per_d;
  logic [DIV_FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [DIV_INT_WIDTH-1:0]  act_int_q, act_int_d;
  logic [DIV_FRAC_WIDTH-1:0] act_frac_q, act_frac_d;
  logic [DIV_INT_WIDTH-1:0]  sh_int_q, sh_int_d;
  logic [DIV_FRAC_WIDTH-1:0] sh_frac_q, sh_frac_d;
  logic                      pend_q, pend_d;
  logic [PhW-1:0]            ph_q, ph_d;
  logic                      rx_q, rx_d;
  logic                      tx_q, tx_d;
  logic [PhW-1:0]            phase_q, phase_d;

  logic                      wrap;
  logic                      carry;
  logic [DIV_FRAC_WIDTH-1:0] acc_sum;

  assign wrap             = (cnt_q == per_q - CntW'(1));
  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, act_frac_q};

  always_comb begin
    cnt_d      = cnt_q;
    per_d      = per_q;
    acc_d      = acc_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    ph_d       = ph_q;
    phase_d    = phase_q;
    rx_d       = 1'b0;
    tx_d       = 1'b0;

    if (bus.i_sync_restart) begin
      cnt_d = '0;
      acc_d = '0;
      ph_d  = '0;
      if (pend_q) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        pend_d     = 1'b0;
        per_d      = eff_int(sh_int_q);
      end else begin
        per_d = eff_int(act_int_q);
      end
    end else if (!bus.i_enable) begin
      // Nothing is counting, so a new divisor can take over immediately.
      if (bus.i_cfg_load) begin
        act_int_d  = bus.i_div_int;
        act_frac_d = bus.i_div_frac;
        pend_d     = 1'b0;
        cnt_d      = '0;
        acc_d      = '0;
        per_d      = eff_int(bus.i_div_int);
      end
    end else begin
      if (bus.i_cfg_load) begin
        sh_int_d  = bus.i_div_int;
        sh_frac_d = bus.i_div_frac;
        pend_d    = 1'b1;
      end
      if (wrap) begin
        cnt_d   = '0;
        rx_d    = 1'b1;
        tx_d    = (ph_q == PhLast);
        phase_d = ph_q;
        ph_d    = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
        // A load landing on this edge only refreshes the shadow; it applies next tick.
        if (pend_q && !bus.i_cfg_load) begin
          act_int_d  = sh_int_q;
          act_frac_d = sh_frac_q;
          pend_d     = 1'b0;
          acc_d      = '0;
          per_d      = eff_int(sh_int_q);
        end else begin
          acc_d = acc_sum;
          per_d = eff_int(act_int_q) + CntW'(carry);
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      per_q      <= eff_int(RstInt);
      acc_q      <= '0;
      act_int_q  <= RstInt;
      act_frac_q <= RstFrac;
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      pend_q     <= 1'b0;
      ph_q       <= '0;
      phase_q    <= '0;
      rx_q       <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      acc_q      <= acc_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      ph_q       <= ph_d;
      phase_q    <= phase_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.o_cfg_pending = pend_q;
  assign bus.o_Rx_clkTick  = rx_q;
  assign bus.o_Tx_clkTick  = tx_q;
  assign bus.o_Rx_phase    = phase_q;

  tx_only_with_rx : assert property (@(posedge clk) disable iff (reset) tx_q |-> rx_q);

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: closed-form tick-time model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_baud_tick_gen;

  localparam int unsigned IW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned OS = 16;
  localparam int unsigned DI = 13;
  localparam int unsigned DF = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  baud_tick_gen_if #(.DIV_INT_WIDTH(IW), .DIV_FRAC_WIDTH(FW), .RX_OVERSAMPLE(OS)) bus ();

  baud_tick_gen #(
    .DIV_INT_WIDTH   (IW),
    .DIV_FRAC_WIDTH  (FW),
    .RX_OVERSAMPLE   (OS),
    .DEFAULT_DIV_INT (DI),
    .DEFAULT_DIV_FRAC(DF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: within a segment (started by reset, restart or divisor apply) with divisor I + F/2^FW,
  // tick number k (0-based) lands on enabled cycle (k+1)*I + floor(k*F / 2^FW).
  longint m_el, m_k, m_nph;
  int     m_i, m_f, m_sh_i, m_sh_f;
  bit     m_pend, e_rx, e_tx;
  int     e_ph;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic longint tick_at(input longint k, input int i, input int f);
    return (k + 1) * i + ((k * f) >> FW);
  endfunction

  task automatic model_reset();
    m_i = DI; m_f = DF; m_el = 0; m_k = 0; m_nph = 0;
    m_pend = 0; m_sh_i = 0; m_sh_f = 0;
    e_rx = 0; e_tx = 0; e_ph = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else if (bus.i_sync_restart) begin
        if (m_pend) begin
          m_i = eff(m_sh_i); m_f = m_sh_f; m_pend = 0;
        end
        m_el = 0; m_k = 0; m_nph = 0; e_rx = 0; e_tx = 0;
      end else if (!bus.i_enable) begin
        e_rx = 0; e_tx = 0;
        if (bus.i_cfg_load) begin
          m_i = eff(int'(bus.i_div_int)); m_f = int'(bus.i_div_frac);
          m_pend = 0; m_el = 0; m_k = 0;
        end
      end else begin
        m_el++;
        if (m_el == tick_at(m_k, m_i, m_f)) begin
          e_rx  = 1;
          e_ph  = int'(m_nph % OS);
          e_tx  = (e_ph == OS - 1);
          m_nph++;
          if (bus.i_cfg_load) begin
            m_sh_i = int'(bus.i_div_int); m_sh_f = int'(bus.i_div_frac); m_pend = 1;
            m_k++;
          end else if (m_pend) begin
            m_i = eff(m_sh_i); m_f = m_sh_f; m_pend = 0; m_el = 0; m_k = 0;
          end else begin
            m_k++;
          end
        end else begin
          e_rx = 0; e_tx = 0;
          if (bus.i_cfg_load) begin
            m_sh_i = int'(bus.i_div_int); m_sh_f = int'(bus.i_div_frac); m_pend = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("rx_tick", longint'(bus.o_Rx_clkTick), longint'(e_rx));
      check("tx_tick", longint'(bus.o_Tx_clkTick), longint'(e_tx));
      check("rx_phase", longint'(bus.o_Rx_phase), longint'(e_ph));
      check("cfg_pending", longint'(bus.o_cfg_pending), longint'(m_pend));
    end
  end

  // Counts negedges until an Rx tick is seen; n is the number of clock edges that elapsed.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_Rx_clkTick && n < limit);
    if (!bus.o_Rx_clkTick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no Rx tick within %0d cycles", limit);
    end
  endtask

  task automatic load_disabled(input int di, input int df);
    @(negedge clk);
    bus.i_enable   = 1'b0;
    bus.i_cfg_load = 1'b1;
    bus.i_div_int  = IW'(di);
    bus.i_div_frac = FW'(df);
    @(negedge clk);
    bus.i_cfg_load = 1'b0;
    check("pending_after_disabled_load", longint'(bus.o_cfg_pending), 0);
    bus.i_sync_restart = 1'b1;
    bus.i_enable       = 1'b1;
    @(negedge clk);
    bus.i_sync_restart = 1'b0;
  endtask

  int n, tot, mn, mx, ph0;

  initial begin
    bus.i_enable       = 1'b1;
    bus.i_sync_restart = 1'b0;
    bus.i_cfg_load     = 1'b0;
    bus.i_div_int      = '0;
    bus.i_div_frac     = '0;
    repeat (3) @(negedge clk);
    check("reset_rx", longint'(bus.o_Rx_clkTick), 0);
    check("reset_phase", longint'(bus.o_Rx_phase), 0);
    reset = 1'b0;

    // Defaults 13 + 9/16: first tick after edge 13, 2000 ticks take 27124 cycles.
    wait_tick(100, n);
    check("default_first_rx_edge", n, 13);
    tot = n; mn = 99; mx = 0;
    for (int t = 1; t < 2000; t++) begin
      wait_tick(100, n);
      tot += n;
      if (n < mn) mn = n;
      if (n > mx) mx = n;
    end
    check("default_2000_total", tot, 27124);
    check("default_min_period", mn, 13);
    check("default_max_period", mx, 14);

    // int=4 frac=0: tick every 4, Tx on 16th tick at edge 64 with phase 15.
    load_disabled(4, 0);
    wait_tick(100, n);
    check("int4_first_rx_edge", n, 4);
    check("int4_first_phase", longint'(bus.o_Rx_phase), 0);
    tot = n;
    for (int t = 2; t <= 32; t++) begin
      wait_tick(100, n);
      tot += n;
      if (t == 16) begin
        check("int4_tx_edge", tot, 64);
        check("int4_tx_tick", longint'(bus.o_Tx_clkTick), 1);
        check("int4_phase16", longint'(bus.o_Rx_phase), 15);
      end
    end
    check("int4_32_total", tot, 128);

    // int=4 frac=8: periods 4,4,5,4,5...; 32 periods after the first total 144.
    load_disabled(4, 8);
    wait_tick(100, n);
    check("frac8_p1", n, 4);
    tot = 0;
    for (int t = 2; t <= 33; t++) begin
      wait_tick(100, n);
      tot += n;
      if (t == 2) check("frac8_p2", n, 4);
      if (t == 3) check("frac8_p3", n, 5);
    end
    check("frac8_32_total", tot, 144);

    // Load int=6 mid-period: old period of 4 still completes, then periods of 6.
    load_disabled(4, 0);
    wait_tick(100, n);
    @(negedge clk);
    bus.i_cfg_load = 1'b1;
    bus.i_div_int  = IW'(6);
    bus.i_div_frac = '0;
    @(negedge clk);
    bus.i_cfg_load = 1'b0;
    check("load6_pending", longint'(bus.o_cfg_pending), 1);
    wait_tick(100, n);
    check("load6_old_period", n + 2, 4);
    check("load6_pending_cleared", longint'(bus.o_cfg_pending), 0);
    for (int t = 0; t < 3; t++) begin
      wait_tick(100, n);
      check("load6_new_period", n, 6);
    end

    // Disable for 10 cycles two cycles into a period; the remaining 4 cycles survive.
    ph0 = int'(bus.o_Rx_phase);
    repeat (2) @(negedge clk);
    bus.i_enable = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("disabled_no_tick", longint'(bus.o_Rx_clkTick), 0);
    end
    bus.i_enable = 1'b1;
    wait_tick(100, n);
    check("reenable_remaining", n, 4);
    check("reenable_phase", longint'(bus.o_Rx_phase), longint'((ph0 + 1) % OS));

    // Restart on a would-be tick edge, then async reset while the next tick is high.
    repeat (5) @(negedge clk);
    bus.i_sync_restart = 1'b1;
    @(negedge clk);
    bus.i_sync_restart = 1'b0;
    check("restart_no_tick", longint'(bus.o_Rx_clkTick), 0);
    wait_tick(100, n);
    check("restart_first_rx", n, 6);
    check("restart_phase0", longint'(bus.o_Rx_phase), 0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_rx", longint'(bus.o_Rx_clkTick), 0);
    check("async_reset_tx", longint'(bus.o_Tx_clkTick), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Randomized control traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      bus.i_enable       = ($urandom_range(0, 99) < 85);
      bus.i_sync_restart = ($urandom_range(0, 199) == 0);
      bus.i_cfg_load     = !bus.i_sync_restart && ($urandom_range(0, 29) == 0);
      bus.i_div_int      = IW'($urandom_range(0, 7));
      bus.i_div_frac     = FW'($urandom_range(0, 15));
      reset              = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    #1;
    reset          = 1'b0;
    bus.i_cfg_load = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable fractional-N baud tick generator for the UART. It generates the single-cycle oversampled receive tick and the derived transmit tick from one system clock. The divisor has an integer part and a fractional part, so standard baud rates come out accurately from arbitrary clocks. Divisor changes are shadowed and applied only at tick boundaries. The block sits between the register/config interface and the UART Rx/Tx state machines.

## Interface
- DIV_INT_WIDTH, 16: width of the integer divisor.
- DIV_FRAC_WIDTH, 4: width of the fractional divisor, in units of 1/2^DIV_FRAC_WIDTH.
- RX_OVERSAMPLE, 16: Rx ticks per Tx tick; must be ≥2.
- DEFAULT_DIV_INT, 13: integer divisor after reset (25 MHz, 115200 baud ×16).
- DEFAULT_DIV_FRAC, 9: fractional divisor after reset (9/16).

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  tick generation enable.
- i_sync_restart  in  1  one-cycle pulse; restarts the bit timing.
- i_cfg_load  in  1  one-cycle pulse; captures the divisor inputs.
- i_div_int  in  DIV_INT_WIDTH  integer divisor.
- i_div_frac  in  DIV_FRAC_WIDTH  fractional divisor.
- o_cfg_pending  out  1  a captured divisor is waiting to be applied.
- o_Rx_clkTick  out  1  single-cycle oversample tick.
- o_Tx_clkTick  out  1  single-cycle bit tick.
- o_Rx_phase  out  $clog2(RX_OVERSAMPLE)  phase index of the current Rx tick.

## Operation
- State:
  - cycle counter cnt (DIV_INT_WIDTH+1 bits)
  - fractional accumulator acc (DIV_FRAC_WIDTH bits)
  - current period register per
  - active divisor pair (act_int, act_frac)
  - shadow divisor pair
  - phase counter ph
- Integer divisor 0 is treated as 1. Minimum period is 1 cycle.
- Counting, when enabled:
  - cnt increments on each clk.
  - When cnt == per−1: cnt←0, o_Rx_clkTick←1, and {carry, acc}←acc+act_frac.
  - The next period is act_int+carry. The average period is act_int + act_frac/2^DIV_FRAC_WIDTH.
  - The first period after reset, restart or divisor apply is act_int. acc is 0 at that point.
- Phase and Tx tick, on each Rx tick:
  - o_Rx_phase←ph.
  - o_Tx_clkTick←(ph==RX_OVERSAMPLE−1).
  - ph←ph+1, wrapping from RX_OVERSAMPLE−1 to 0. Non-power-of-two RX_OVERSAMPLE wraps correctly.
- Tick outputs are registered and high for exactly one cycle. o_Tx_clkTick is only ever high together with o_Rx_clkTick.
- i_enable low:
  - cnt, acc, ph and per are frozen; both ticks are 0.
  - On re-enable, counting resumes from the frozen state.
- i_sync_restart:
  - cnt, acc and ph go to 0; no tick is produced that cycle.
  - A pending divisor is applied immediately.
  - per←act_int, using the newly applied value if one was pending.
- i_cfg_load:
  - Captures i_div_int/i_div_frac into the shadow and sets o_cfg_pending.
  - A second load while pending overwrites the shadow.
- Apply rule:
  - A pending shadow becomes active on the edge that generates the next Rx tick. That edge sets acc←0, per←new int, and clears o_cfg_pending. The tick itself is still produced.
  - If i_enable is low, the load applies directly on its capture edge, with cnt and acc cleared and ph kept. o_cfg_pending stays 0.
  - A load coincident with a tick edge is captured only and applies at the following tick.
- Priority: reset > i_sync_restart > i_cfg_load capture/apply > counting.

## Timing
- Reset values:
  - All outputs 0.
  - cnt=0, acc=0, ph=0.
  - act_int=DEFAULT_DIV_INT, act_frac=DEFAULT_DIV_FRAC, per=DEFAULT_DIV_INT.
- Reset is asynchronous. Asserting it mid-period or mid-tick clears the tick outputs immediately and discards any pending config.
- After reset deassertion with i_enable high, let edge 1 be the first rising clk edge. The first Rx tick is high after edge per, for one cycle.
- With RX_OVERSAMPLE=16, the first Tx tick coincides with the 16th Rx tick and o_Rx_phase=15.
- i_sync_restart high at edge E: the first Rx tick is high after edge E+act_int.
- Divisor apply latency is at most one Rx period plus one cycle.

## Test plan
- int=4, frac=0, OVERSAMPLE=16 -> Rx tick every 4 cycles, first after edge 4; Tx tick every 64 cycles, first after edge 64; o_Rx_phase counts 0..15.
- int=4, frac=8, DIV_FRAC_WIDTH=4 -> periods 4,4,5,4,5,…; any 32 consecutive periods after the first total exactly 144 cycles.
- Defaults (13, 9/16) for 16 000 Rx ticks -> total cycles within ±13 of 217 000; no period other than 13 or 14.
- Load int=6 mid-period while enabled -> o_cfg_pending=1 until the next tick; that tick still ends the old period; all following periods are 6; pending clears on that tick edge.
- i_enable low for 10 cycles mid-period, then high -> no ticks while low; the remaining cycles of the period are preserved; ph unchanged.
- i_sync_restart in the same cycle as a would-be tick, plus reset asserted mid-tick -> no tick on the restart cycle; next tick after act_int edges with o_Rx_phase=0; reset forces o_Rx_clkTick=0 asynchronously.
